// File: rtl/rv32i_defs.sv
// Shared RV32I front-end constants and the prefetch entry layout.
package rv32i_defs;

    localparam int          XLEN    = 32;
    localparam int          INST_W  = 32;
    localparam int          PC_STEP = 4;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    // Entry layout of the prefetch FIFO: {pc, instruction}.
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with push/pop/flush; flush wins over push and pop.
module fetch_fifo
    import rv32i_defs::*;
#(
    parameter int WIDTH = XLEN + INST_W,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    input  logic                           flush,
    output logic [WIDTH-1:0]               head_data,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en;

    assign wr_en     = push && !flush;
    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage is reset so the head reads as zero while reset is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (wr_en) mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch front end: credit-limited imem requests, in-order prefetch FIFO, redirect flush.
// Optional perf counters (perf_fetched/perf_flushed) are built when FETCH_PERF_CNT_EN is defined.
module instr_fetch_unit
    import rv32i_defs::*;
#(
    parameter int              XLEN       = rv32i_defs::XLEN,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   inst_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_flushed
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int EW = XLEN + INST_W;

    // Handshakes: a request transfers when imem_req_valid && imem_req_ready;
    // a response transfers whenever imem_rsp_valid is high (no backpressure);
    // decode consumes the head when inst_valid && inst_ready.
    logic            run_q, run_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   discard_q, discard_d;

    logic [CW-1:0]   fifo_count;
    logic [EW-1:0]   fifo_head;
    logic [CW:0]     credits_used;
    logic [XLEN-1:0] redirect_base;
    logic            req_fire, rsp_drop, push, pop;
    logic            unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign redirect_base        = {redirect_pc[XLEN-1:2], 2'b00};
    assign credits_used         = {1'b0, inflight_q} + {1'b0, fifo_count};

    // run_q keeps the request port quiet until the first cycle after reset release.
    assign imem_req_valid = run_q && !redirect_valid && (credits_used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = run_q ? fetch_pc_q : '0;
    assign inst_valid     = (fifo_count != '0) && !redirect_valid;
    assign inst           = fifo_head[INST_W-1:0];
    assign inst_pc        = fifo_head[EW-1:INST_W];

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_drop = redirect_valid || (discard_q != '0);
    assign push     = imem_rsp_valid && !rsp_drop;
    assign pop      = inst_valid && inst_ready;

    always_comb begin
        run_d      = 1'b1;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        discard_d  = discard_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
        if (redirect_valid) begin
            fetch_pc_d = redirect_base;
            resp_pc_d  = redirect_base;
            // inflight already includes responses marked for discard, so every
            // outstanding response except the one arriving now must be dropped.
            discard_d  = inflight_q - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
            if (push)     resp_pc_d  = resp_pc_q + XLEN'(PC_STEP);
            if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q      <= 1'b0;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            run_q      <= run_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({resp_pc_q, imem_rsp_data}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_flushed_q, perf_flushed_d;
    logic [32:0] flushed_sum;

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        if (push && (perf_fetched_q != '1)) perf_fetched_d = perf_fetched_q + 32'd1;
        flushed_sum = {1'b0, perf_flushed_q}
                    + 33'(imem_rsp_valid && rsp_drop)
                    + (redirect_valid ? 33'(fifo_count) : 33'd0);
        perf_flushed_d = flushed_sum[32] ? '1 : flushed_sum[31:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

    rsp_needs_inflight: assert property (@(posedge clk) disable iff (!rst)
        imem_rsp_valid |-> (inflight_q != '0));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: imem model with configurable latency, expected-stream scoreboard.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    instr_fetch_unit #(
        .XLEN       (32),
        .FIFO_DEPTH (4),
        .RESET_PC   (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // ---------------- model state / scoreboard ----------------
    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;

    typedef struct {
        int          lat;
        int          req_pct;
        int          rdy_pct;
        int          ncyc;
        logic [31:0] rpc;
        logic [31:0] exp_pc;
    } vec_t;

    logic [63:0] exp_q[$];
    pend_t       pend_q[$];
    vec_t        vecs[5];

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          lat = 1;
    int          acc_cnt = 0;
    int          pop_cnt = 0;
    logic [31:0] first_pc, last_pc;
    logic        s_req_valid, s_inst_valid;
    logic [31:0] s_req_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0019_660D) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ---------------- driver tasks ----------------
    // One clock cycle: sample at negedge, update the model at posedge, drive at posedge+1.
    task automatic step();
        logic        rf, pf, rd;
        logic [31:0] a;
        logic [63:0] e;
        pend_t       p;
        @(negedge clk);
        s_req_valid  = imem_req_valid;
        s_req_addr   = imem_req_addr;
        s_inst_valid = inst_valid;
        rf = imem_req_valid && imem_req_ready;
        pf = inst_valid && inst_ready;
        rd = redirect_valid;
        a  = imem_req_addr;
        if (pf) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got pc %0h expected no instruction", inst_pc);
            end else begin
                e = exp_q.pop_front();
                chk("inst_pc", {32'h0, inst_pc}, {32'h0, e[63:32]});
                chk("inst", {32'h0, inst}, {32'h0, e[31:0]});
            end
            if (pop_cnt == 0) first_pc = inst_pc;
            last_pc = inst_pc;
            pop_cnt++;
        end
        @(posedge clk);
        cyc++;
        if (imem_rsp_valid) void'(pend_q.pop_front());
        if (rd) exp_q.delete();
        if (rf) begin
            acc_cnt++;
            p.due  = cyc + lat - 1;
            p.addr = a;
            pend_q.push_back(p);
            exp_q.push_back({a, mem_word(a)});
        end
        #1;
        redirect_valid = 1'b0;
        if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    // Entered at posedge+1; leaves with rst released at posedge+1.
    task automatic do_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        pend_q.delete();
        exp_q.delete();
        #1;
        chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        chk("rst_req_addr", {32'h0, imem_req_addr}, 64'h0);
        chk("rst_inst_valid", {63'h0, inst_valid}, 64'h0);
        chk("rst_inst", {32'h0, inst}, 64'h0);
        chk("rst_inst_pc", {32'h0, inst_pc}, 64'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf_fetched", {32'h0, perf_fetched}, 64'h0);
        chk("rst_perf_flushed", {32'h0, perf_flushed}, 64'h0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b1;
        acc_cnt = 0;
        pop_cnt = 0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vecs[0] = '{1, 100, 100, 30, 32'h0000_1000, 32'h0000_1000};
        vecs[1] = '{2,  70,  50, 40, 32'h0000_2002, 32'h0000_2000};
        vecs[2] = '{3, 100,  30, 40, 32'h0000_3001, 32'h0000_3000};
        vecs[3] = '{1,  50, 100, 40, 32'hFFFF_FFF0, 32'hFFFF_FFF0};
        vecs[4] = '{4,  90,  80, 50, 32'h0000_0403, 32'h0000_0400};

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        inst_ready     = 1'b1;
        #1;

        // 1: streaming from reset, latency 1
        lat = 1;
        do_reset();
        step();
        chk("t1_no_req_release_cycle", {63'h0, s_req_valid}, 64'h0);
        step();
        chk("t1_first_req_valid", {63'h0, s_req_valid}, 64'h1);
        chk("t1_first_req_addr", {32'h0, s_req_addr}, 64'h0);
        step();
        chk("t1_inst_valid_rsp_cycle", {63'h0, s_inst_valid}, 64'h0);
        step();
        chk("t1_inst_valid_next", {63'h0, s_inst_valid}, 64'h1);
        chk("t1_first_pc", {32'h0, first_pc}, 64'h0);
        for (int i = 0; i < 20 && pop_cnt < 4; i++) step();
        chk("t1_pops", pop_cnt, 4);
        chk("t1_fourth_pc", {32'h0, last_pc}, 64'hC);

        // 2: decode stalled; credits stop fetch at FIFO_DEPTH
        inst_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 20; i++) step();
        chk("t2_accepted", acc_cnt, 4);
        chk("t2_req_valid_blocked", {63'h0, s_req_valid}, 64'h0);
        chk("t2_inst_valid", {63'h0, s_inst_valid}, 64'h1);
        inst_ready = 1'b1;
        for (int i = 0; i < 40 && pop_cnt < 5; i++) step();
        chk("t2_pops", pop_cnt, 5);
        chk("t2_first_pc", {32'h0, first_pc}, 64'h0);
        chk("t2_fifth_pc", {32'h0, last_pc}, 64'h10);

        // 3: latency 3, redirect with two requests in flight
        lat = 3;
        do_reset();
        for (int i = 0; i < 10 && acc_cnt < 2; i++) step();
        chk("t3_accepted", acc_cnt, 2);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0104;
        step();
        chk("t3_redirect_req_valid", {63'h0, s_req_valid}, 64'h0);
        chk("t3_redirect_inst_valid", {63'h0, s_inst_valid}, 64'h0);
        imem_req_ready = 1'b1;
        for (int i = 0; i < 60 && pop_cnt < 2; i++) step();
        chk("t3_pops", pop_cnt, 2);
        chk("t3_first_pc", {32'h0, first_pc}, 64'h104);
        chk("t3_second_pc", {32'h0, last_pc}, 64'h108);
        imem_req_ready = 1'b0;
        for (int i = 0; i < 20; i++) step();
`ifdef FETCH_PERF_CNT_EN
        chk("t6_perf_flushed", {32'h0, perf_flushed}, 64'h2);
        chk("t6_perf_fetched", {32'h0, perf_fetched}, 64'(pop_cnt));
`endif
        imem_req_ready = 1'b1;

        // 4: redirect coinciding with a response and a ready decode stage
        lat = 1;
        do_reset();
        for (int i = 0; i < 8; i++) step();
        for (int i = 0; i < 10 && !(imem_rsp_valid && s_inst_valid); i++) step();
        chk("t4_setup_inst_valid", {63'h0, s_inst_valid}, 64'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        pop_cnt = 0;
        step();
        chk("t4_redirect_inst_valid", {63'h0, s_inst_valid}, 64'h0);
        chk("t4_no_pop", pop_cnt, 0);
        step();
        chk("t4_inst_valid_after", {63'h0, s_inst_valid}, 64'h0);
        for (int i = 0; i < 20 && pop_cnt < 1; i++) step();
        chk("t4_pops", pop_cnt, 1);
        chk("t4_first_pc", {32'h0, first_pc}, 64'h200);

        // 5: reset asserted mid-stream
        for (int i = 0; i < 5; i++) step();
        chk("t5_midstream_inst_valid", {63'h0, s_inst_valid}, 64'h1);
        do_reset();
        step();
        step();
        chk("t5_req_valid", {63'h0, s_req_valid}, 64'h1);
        chk("t5_req_addr", {32'h0, s_req_addr}, 64'h0);
        for (int i = 0; i < 10; i++) step();

        // table: redirect at the start of each phase, random handshakes
        foreach (vecs[r]) begin
            lat            = vecs[r].lat;
            pop_cnt        = 0;
            redirect_valid = 1'b1;
            redirect_pc    = vecs[r].rpc;
            imem_req_ready = ($urandom_range(99) < vecs[r].req_pct);
            inst_ready     = ($urandom_range(99) < vecs[r].rdy_pct);
            step();
            for (int i = 0; i < vecs[r].ncyc; i++) begin
                imem_req_ready = ($urandom_range(99) < vecs[r].req_pct);
                inst_ready     = ($urandom_range(99) < vecs[r].rdy_pct);
                step();
            end
            chk("vec_pops_seen", {63'h0, pop_cnt != 0}, 64'h1);
            chk("vec_first_pc", {32'h0, first_pc}, {32'h0, vecs[r].exp_pc});
        end

        // drain
        imem_req_ready = 1'b0;
        inst_ready     = 1'b1;
        for (int i = 0; i < 30; i++) step();
        chk("drain_exp_q_empty", 64'(exp_q.size()), 64'h0);
        chk("drain_inst_valid", {63'h0, s_inst_valid}, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
